// File: rtl/tbus_pkg.sv
// tbus_pkg: shared types and width helpers for the tristate bus reader.
//   idx_w()       - index width for n items (never below 1 bit)
//   state_t       - reader FSM states
//   tbus_entry_t  - queue entry {src, data} at the default widths
package tbus_pkg;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_NSRC   = 4;
    localparam int DEF_DEPTH  = 4;
    localparam int DEF_SETTLE = 2;
    localparam int DEF_TURN   = 1;
    localparam int DEF_SRC_W  = idx_w(DEF_NSRC);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        GAP
    } state_t;

    typedef struct packed {
        logic [DEF_SRC_W-1:0] src;
        logic [DEF_WIDTH-1:0] data;
    } tbus_entry_t;

endpackage

// File: rtl/tbus_fifo.sv
// tbus_fifo: DEPTH-entry synchronous FIFO with registered head.
//   CK, RN  - clock, async active-low reset
//   push/din - write one entry (caller guarantees not full)
//   pop      - consume head; ignored while empty
//   dout     - head entry, valid - head present, count - occupancy
module tbus_fifo #(
    parameter int EW    = 12,
    parameter int DEPTH = 4
) (
    input  logic                   CK,
    input  logic                   RN,
    input  logic                   push,
    input  logic [EW-1:0]          din,
    input  logic                   pop,
    output logic [EW-1:0]          dout,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          do_pop;

    assign do_pop = pop && valid;

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wp] <= din;
                wp      <= wp + 1'b1;
            end
            if (do_pop) rp <= rp + 1'b1;
            // simultaneous push and pop leaves occupancy unchanged
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // head comes straight from storage flops, so there is no path from pop
    assign dout  = mem[rp];
    assign valid = (count != '0);

endmodule

// File: rtl/tbus_reader.sv
// tbus_reader: reading end of a shared tristate bus.
//   CK, RN   - clock, async active-low reset
//   REQ      - per-source data pending, held until ACK
//   OE       - registered per-source output enable, one-hot or zero
//   ACK      - one-cycle pulse once a source's word is captured
//   BUS      - resolved shared bus
//   Q/QSRC/QV/QR - head-of-queue data, source index, valid, ready
// Round-robin grant, SETTLE cycles of drive, sample, then TURN cycles
// with every OE low before the next grant.
module tbus_reader
    import tbus_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NSRC   = DEF_NSRC,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int SETTLE = DEF_SETTLE,
    parameter int TURN   = DEF_TURN
) (
    input  logic                   CK,
    input  logic                   RN,
    input  logic [NSRC-1:0]        REQ,
    output logic [NSRC-1:0]        OE,
    output logic [NSRC-1:0]        ACK,
    input  logic [WIDTH-1:0]       BUS,
    output logic [WIDTH-1:0]       Q,
    output logic [idx_w(NSRC)-1:0] QSRC,
    output logic                   QV,
    input  logic                   QR
);

    localparam int SW   = idx_w(NSRC);
    localparam int MAXC = (SETTLE > TURN) ? SETTLE : TURN;
    localparam int CW   = idx_w(MAXC);
    localparam int QCW  = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [SW-1:0]    src;
        logic [WIDTH-1:0] data;
    } entry_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   ptr_q, ptr_d, win;
    logic [NSRC-1:0] oe_d, ack_d;
    logic [QCW-1:0]  qcount;
    logic            start, push;
    entry_t          push_e, head_e;

    // first pending source strictly after the pointer, with wrap;
    // descending scan so the nearest candidate is written last
    always_comb begin
        int j;
        win = ptr_q;
        for (int i = NSRC; i >= 1; i--) begin
            j = (int'(ptr_q) + i) % NSRC;
            if (REQ[j]) win = SW'(j);
        end
    end

    // at most one transfer in flight, so gating here prevents overflow
    assign start = (|REQ) && (qcount < QCW'(DEPTH));

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= SW'(NSRC - 1);
            OE      <= '0;
            ACK     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            OE      <= oe_d;
            ACK     <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: if (start) begin
                state_d = DRIVE;
                cnt_d   = CW'(SETTLE - 1);
                ptr_d   = win;
            end
            DRIVE: if (cnt_q == '0) begin
                state_d = GAP;
                cnt_d   = CW'(TURN - 1);
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            GAP: if (cnt_q == '0) state_d = IDLE;
                 else             cnt_d   = cnt_q - 1'b1;
            default: state_d = IDLE;
        endcase
    end

    // during DRIVE the pointer already holds the winner
    always_comb begin
        oe_d  = '0;
        ack_d = '0;
        push  = 1'b0;
        case (state_q)
            IDLE:  if (start) oe_d[win] = 1'b1;
            DRIVE: if (cnt_q == '0) begin
                push         = 1'b1;
                ack_d[ptr_q] = 1'b1;
            end else begin
                oe_d = OE;
            end
            default: ;
        endcase
    end

    assign push_e.src  = ptr_q;
    assign push_e.data = BUS;

    tbus_fifo #(
        .EW    ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CK    (CK),
        .RN    (RN),
        .push  (push),
        .din   (push_e),
        .pop   (QR),
        .dout  (head_e),
        .valid (QV),
        .count (qcount)
    );

    assign Q    = head_e.data;
    assign QSRC = head_e.src;

endmodule

// File: tb/tb_tbus_reader.sv
module tb_tbus_reader;

    logic       CK = 1'b0;
    logic       RN;
    logic [3:0] REQ, OE, ACK;
    logic [7:0] BUS, Q;
    logic [1:0] QSRC;
    logic       QV, QR;

    logic [3:0] req2, oe2, ack2;
    logic [7:0] bus2, q2;
    logic [1:0] qsrc2;
    logic       qv2, qr2;

    int checks   = 0;
    int failures = 0;
    int grants   = 0;
    int g0;
    logic [3:0] prev_oe  = 4'b0;
    logic [3:0] prev_oe2 = 4'b0;

    tbus_reader dut (
        .CK(CK), .RN(RN), .REQ(REQ), .OE(OE), .ACK(ACK), .BUS(BUS),
        .Q(Q), .QSRC(QSRC), .QV(QV), .QR(QR)
    );

    tbus_reader #(.SETTLE(1), .TURN(3)) dut2 (
        .CK(CK), .RN(RN), .REQ(req2), .OE(oe2), .ACK(ack2), .BUS(bus2),
        .Q(q2), .QSRC(qsrc2), .QV(qv2), .QR(qr2)
    );

    always #5 CK = ~CK;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    // one full transfer from IDLE on the default instance; QR only at the capture edge
    task automatic run_xfer(input logic [3:0] r, input logic [7:0] d, input logic qrcap);
        REQ = r; BUS = d; QR = 1'b0;
        step();
        step();
        QR = qrcap;
        step();
        QR = 1'b0;
        step();
    endtask

    // bus protocol monitor: one-hot OE and no direct handover between sources
    always @(negedge CK) begin
        if (RN) begin
            chk("oe_onehot",  32'($onehot0(OE)),  32'd1);
            chk("oe_gap",     32'(prev_oe != 0 && OE != 0 && OE != prev_oe), 32'd0);
            chk("oe2_onehot", 32'($onehot0(oe2)), 32'd1);
            chk("oe2_gap",    32'(prev_oe2 != 0 && oe2 != 0 && oe2 != prev_oe2), 32'd0);
            if (OE != 0 && prev_oe == 0) grants++;
        end
        prev_oe  = OE;
        prev_oe2 = oe2;
    end

    typedef struct {
        logic [3:0] req;
        logic [7:0] bus;
        logic       qr;
        logic [3:0] oe;
        logic [3:0] ack;
        logic       qv;
        logic [7:0] q;
        logic [1:0] qsrc;
    } vec_t;

    vec_t vt [25];
    logic [7:0] exp_q [4];

    initial begin
        // fairness: 5 grants at 4 cycles each, order 0,1,2,3,0
        for (int g = 0; g < 5; g++) begin
            for (int k = 0; k < 4; k++) begin
                vt[4*g+k].req  = 4'b1111;
                vt[4*g+k].bus  = 8'h10 + 8'(g);
                vt[4*g+k].qr   = 1'b1;
                vt[4*g+k].oe   = (k < 2) ? (4'b0001 << (g % 4)) : 4'b0000;
                vt[4*g+k].ack  = (k == 2) ? (4'b0001 << (g % 4)) : 4'b0000;
                vt[4*g+k].qv   = (k == 2);
                vt[4*g+k].q    = 8'h10 + 8'(g);
                vt[4*g+k].qsrc = 2'(g % 4);
            end
        end
        // single source 1
        vt[20] = '{4'b0010, 8'hA5, 1'b1, 4'b0010, 4'b0000, 1'b0, 8'h00, 2'd0};
        vt[21] = '{4'b0010, 8'hA5, 1'b1, 4'b0010, 4'b0000, 1'b0, 8'h00, 2'd0};
        vt[22] = '{4'b0010, 8'hA5, 1'b1, 4'b0000, 4'b0010, 1'b1, 8'hA5, 2'd1};
        vt[23] = '{4'b0000, 8'hA5, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 2'd0};
        vt[24] = '{4'b0000, 8'hA5, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 2'd0};

        RN = 1'b0; REQ = '0; BUS = '0; QR = 1'b0;
        req2 = '0; bus2 = '0; qr2 = 1'b1;
        repeat (2) @(posedge CK);
        #1;
        chk("rst_oe",   32'(OE),   32'd0);
        chk("rst_ack",  32'(ACK),  32'd0);
        chk("rst_qv",   32'(QV),   32'd0);
        chk("rst_q",    32'(Q),    32'd0);
        chk("rst_qsrc", 32'(QSRC), 32'd0);
        chk("rst_qv2",  32'(qv2),  32'd0);
        RN = 1'b1;

        for (int r = 0; r < 25; r++) begin
            REQ = vt[r].req; BUS = vt[r].bus; QR = vt[r].qr;
            step();
            chk($sformatf("v%0d_oe", r),  32'(OE),  32'(vt[r].oe));
            chk($sformatf("v%0d_ack", r), 32'(ACK), 32'(vt[r].ack));
            chk($sformatf("v%0d_qv", r),  32'(QV),  32'(vt[r].qv));
            if (vt[r].qv) begin
                chk($sformatf("v%0d_q", r),    32'(Q),    32'(vt[r].q));
                chk($sformatf("v%0d_qsrc", r), 32'(QSRC), 32'(vt[r].qsrc));
            end
        end

        // backpressure: four words fill the queue, then no further grant
        g0 = grants;
        for (int j = 0; j < 4; j++) run_xfer(4'b0001, 8'hB0 + 8'(j), 1'b0);
        for (int j = 0; j < 6; j++) begin
            step();
            chk("bp_oe_idle", 32'(OE), 32'd0);
        end
        chk("bp_grants4", 32'(grants - g0), 32'd4);
        chk("bp_qv",      32'(QV),   32'd1);
        chk("bp_head",    32'(Q),    32'hB0);
        chk("bp_qsrc",    32'(QSRC), 32'd0);
        QR = 1'b1;
        step();
        QR = 1'b0;
        chk("bp_pop_head", 32'(Q),  32'hB1);
        chk("bp_pop_oe",   32'(OE), 32'd0);
        run_xfer(4'b0001, 8'hC0, 1'b0);
        REQ = 4'b0000;
        chk("bp_grants5", 32'(grants - g0), 32'd5);
        exp_q[0] = 8'hB1; exp_q[1] = 8'hB2; exp_q[2] = 8'hB3; exp_q[3] = 8'hC0;
        QR = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("bp_drain%0d_qv", j), 32'(QV), 32'd1);
            chk($sformatf("bp_drain%0d_q", j),  32'(Q),  32'(exp_q[j]));
            step();
        end
        chk("bp_empty", 32'(QV), 32'd0);
        QR = 1'b0;

        // push and pop on the same edge at count DEPTH-1
        for (int j = 0; j < 3; j++) run_xfer(4'b0001, 8'hD0 + 8'(j), 1'b0);
        run_xfer(4'b0001, 8'hD3, 1'b1);
        REQ = 4'b0000;
        chk("pp_head", 32'(Q), 32'hD1);
        exp_q[0] = 8'hD1; exp_q[1] = 8'hD2; exp_q[2] = 8'hD3;
        QR = 1'b1;
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("pp_drain%0d_qv", j), 32'(QV), 32'd1);
            chk($sformatf("pp_drain%0d_q", j),  32'(Q),  32'(exp_q[j]));
            step();
        end
        chk("pp_empty", 32'(QV), 32'd0);
        QR = 1'b0;

        // reset while source 2 drives, with one word already queued
        run_xfer(4'b0100, 8'hE0, 1'b0);
        step();
        chk("rd_oe_before", 32'(OE), 32'b0100);
        chk("rd_qv_before", 32'(QV), 32'd1);
        #2 RN = 1'b0;
        #1;
        chk("rd_oe_async",  32'(OE),  32'd0);
        chk("rd_qv_async",  32'(QV),  32'd0);
        chk("rd_ack_async", 32'(ACK), 32'd0);
        REQ = 4'b0101;
        for (int j = 0; j < 2; j++) begin
            step();
            chk("rd_ack_held", 32'(ACK), 32'd0);
            chk("rd_oe_held",  32'(OE),  32'd0);
        end
        RN = 1'b1;
        step();
        chk("rd_first_grant", 32'(OE), 32'b0001);
        REQ = 4'b0000; QR = 1'b1;
        repeat (4) step();
        QR = 1'b0;

        // SETTLE=1/TURN=3 instance: REQ withdrawn mid-drive, 5-cycle period
        req2 = 4'b0001; bus2 = 8'h77;
        step();
        chk("wd_oe",   32'(oe2), 32'b0001);
        req2 = 4'b0000;
        step();
        chk("wd_ack",  32'(ack2),  32'b0001);
        chk("wd_oe0",  32'(oe2),   32'd0);
        chk("wd_qv",   32'(qv2),   32'd1);
        chk("wd_q",    32'(q2),    32'h77);
        chk("wd_qsrc", 32'(qsrc2), 32'd0);
        req2 = 4'b0010;
        for (int j = 0; j < 3; j++) begin
            step();
            chk($sformatf("wd_gap%0d_oe", j), 32'(oe2), 32'd0);
            if (j == 0) chk("wd_ack_pulse", 32'(ack2), 32'd0);
        end
        step();
        chk("wd_period5", 32'(oe2), 32'b0010);
        req2 = 4'b0000;
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
